// File: rtl/demux1to2_stream.sv
// 1-to-2 stream demultiplexer: routes each input word into one of two 2-deep
// output FIFOs, either by in_sel or round-robin, and counts words delivered per port.

module demux1to2_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_full,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [7:0]       o_cnt
);
    logic [1:0][WIDTH-1:0] r_mem;
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_occ;
    logic [7:0]            r_cnt;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_occ == 2'd2);
    assign o_valid = (r_occ != 2'd0);
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;
    assign o_cnt   = r_cnt;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_ready && o_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_occ  <= 2'd0;
            r_cnt  <= 8'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
                r_cnt  <= r_cnt + 8'd1;
            end
            // Simultaneous push and pop leaves occupancy unchanged
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule

module demux1to2_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
);
    localparam int NUM_LANES = 2;

    logic                            r_toggle;
    logic                            w_dest;
    logic                            w_xfer;
    logic [NUM_LANES-1:0]            w_full;
    logic [NUM_LANES-1:0]            w_valid;
    logic [NUM_LANES-1:0]            w_ready;
    logic [NUM_LANES-1:0][WIDTH-1:0] w_data;
    logic [NUM_LANES-1:0][7:0]       w_cnt;

    assign w_dest   = mode ? r_toggle : in_sel;
    // Stall on a full destination even if the other FIFO has room
    assign in_ready = !rst && !w_full[w_dest];
    assign w_xfer   = in_valid && in_ready;
    assign w_ready  = {out1_ready, out0_ready};

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            demux1to2_fifo2 #(.WIDTH(WIDTH)) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_xfer && (w_dest == 1'(g))),
                .i_data  (in_data),
                .i_ready (w_ready[g]),
                .o_full  (w_full[g]),
                .o_valid (w_valid[g]),
                .o_data  (w_data[g]),
                .o_cnt   (w_cnt[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            r_toggle <= 1'b0;
        else if (w_xfer && mode)
            r_toggle <= ~r_toggle;
    end

    assign out0_valid = w_valid[0];
    assign out1_valid = w_valid[1];
    assign out0_data  = w_data[0];
    assign out1_data  = w_data[1];
    assign cnt0       = w_cnt[0];
    assign cnt1       = w_cnt[1];
endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed bench for demux1to2_stream: inputs change 1 time unit after the
// rising edge, outputs are checked before the next edge.

module tb_demux1to2_stream;
    logic       clk = 1'b0;
    logic       rst, mode, in_sel, in_valid, in_ready;
    logic [7:0] in_data;
    logic       out0_valid, out0_ready, out1_valid, out1_ready;
    logic [7:0] out0_data, out1_data, cnt0, cnt1;
    int         nvec = 0;
    int         nerr = 0;

    demux1to2_stream #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; in_sel = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        out0_ready = 1'b0; out1_ready = 1'b0;
        tick(); tick();
        chk("rst_v0",    32'(out0_valid), 32'h0);
        chk("rst_v1",    32'(out1_valid), 32'h0);
        chk("rst_d0",    32'(out0_data),  32'h0);
        chk("rst_d1",    32'(out1_data),  32'h0);
        chk("rst_cnt0",  32'(cnt0),       32'h0);
        chk("rst_cnt1",  32'(cnt1),       32'h0);
        chk("rst_rdy",   32'(in_ready),   32'h0);
        rst = 1'b0; settle();
        chk("rst_rdy_after", 32'(in_ready), 32'h1);

        // Single word to port 0
        in_valid = 1'b1; in_data = 8'hA5; out0_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("s1_v0",    32'(out0_valid), 32'h1);
        chk("s1_d0",    32'(out0_data),  32'hA5);
        chk("s1_v1",    32'(out1_valid), 32'h0);
        tick();
        chk("s1_cnt0",  32'(cnt0),       32'h1);
        chk("s1_v0_empty", 32'(out0_valid), 32'h0);
        chk("s1_d0_empty", 32'(out0_data),  32'h0);

        // Port 1 backpressure: two accepted, third stalls until space frees
        out0_ready = 1'b0; in_sel = 1'b1; out1_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; settle();
        chk("s2_rdy0", 32'(in_ready), 32'h1);
        tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; settle();
        chk("s2_rdy_full", 32'(in_ready), 32'h0);
        chk("s2_head",     32'(out1_data), 32'h11);
        tick();
        chk("s2_stall_head", 32'(out1_data), 32'h11);
        chk("s2_stall_rdy",  32'(in_ready),  32'h0);
        out1_ready = 1'b1; settle();
        chk("s2_rdy_no_bypass", 32'(in_ready), 32'h0);
        tick();
        chk("s2_d22",  32'(out1_data), 32'h22);
        chk("s2_rdy1", 32'(in_ready),  32'h1);
        tick();
        in_valid = 1'b0;
        chk("s2_d33",  32'(out1_data), 32'h33);
        chk("s2_cnt1_2", 32'(cnt1), 32'h2);
        tick();
        chk("s2_cnt1_3", 32'(cnt1),       32'h3);
        chk("s2_v1_empty", 32'(out1_valid), 32'h0);

        // Round-robin routing from a clean toggle
        do_reset();
        mode = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h01; tick();
        in_data = 8'h02;
        chk("s3_d01", 32'(out0_data), 32'h01);
        chk("s3_v1_0", 32'(out1_valid), 32'h0);
        tick();
        in_data = 8'h03;
        chk("s3_d02", 32'(out1_data), 32'h02);
        chk("s3_v0_0", 32'(out0_valid), 32'h0);
        tick();
        in_data = 8'h04;
        chk("s3_d03", 32'(out0_data), 32'h03);
        tick();
        in_valid = 1'b0;
        chk("s3_d04", 32'(out1_data), 32'h04);
        tick();
        chk("s3_cnt0", 32'(cnt0), 32'h2);
        chk("s3_cnt1", 32'(cnt1), 32'h2);

        // Push and pop together on port 0 at occupancy 1
        mode = 1'b0; in_sel = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A; tick();
        in_data = 8'h6B; out0_ready = 1'b1; settle();
        chk("s4_rdy_pre", 32'(in_ready), 32'h1);
        chk("s4_head",    32'(out0_data), 32'h5A);
        tick();
        in_valid = 1'b0; out0_ready = 1'b0; settle();
        chk("s4_v0",   32'(out0_valid), 32'h1);
        chk("s4_d6b",  32'(out0_data),  32'h6B);
        chk("s4_rdy",  32'(in_ready),   32'h1);
        chk("s4_cnt0", 32'(cnt0),       32'h3);
        out0_ready = 1'b1; tick();
        chk("s4_cnt0_b", 32'(cnt0),       32'h4);
        chk("s4_v0_empty", 32'(out0_valid), 32'h0);

        // 256 words through port 1: counter wraps
        do_reset();
        out0_ready = 1'b0; in_sel = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1; in_data = 8'(i); tick();
            in_valid = 1'b0; tick();
            if (i == 254) chk("s5_cnt1_255", 32'(cnt1), 32'hFF);
        end
        chk("s5_cnt1_wrap", 32'(cnt1),       32'h0);
        chk("s5_v1_empty",  32'(out1_valid), 32'h0);
        chk("s5_cnt0",      32'(cnt0),       32'h0);

        // Fill both FIFOs with toggle left at 1, then reset mid-operation
        out1_ready = 1'b0;
        mode = 1'b1; in_valid = 1'b1; in_data = 8'hC0; tick();
        mode = 1'b0; in_sel = 1'b0; in_data = 8'hC1; tick();
        settle();
        chk("s6_stall_dest_full", 32'(in_ready), 32'h0);
        in_sel = 1'b1; in_data = 8'hD0; tick();
        in_data = 8'hD1; tick();
        in_valid = 1'b0; mode = 1'b1; settle();
        chk("s6_full_rdy_rr", 32'(in_ready),   32'h0);
        chk("s6_v0", 32'(out0_valid), 32'h1);
        chk("s6_v1", 32'(out1_valid), 32'h1);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out0_ready = 1'b1; out1_ready = 1'b1;
        settle();
        chk("s6_rdy_in_rst", 32'(in_ready), 32'h0);
        tick();
        chk("s6_rst_v0",   32'(out0_valid), 32'h0);
        chk("s6_rst_v1",   32'(out1_valid), 32'h0);
        chk("s6_rst_d0",   32'(out0_data),  32'h0);
        chk("s6_rst_cnt0", 32'(cnt0),       32'h0);
        chk("s6_rst_cnt1", 32'(cnt1),       32'h0);
        rst = 1'b0; in_valid = 1'b1; in_data = 8'h77; out0_ready = 1'b0; out1_ready = 1'b0;
        settle();
        chk("s6_rdy_after_rst", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("s6_toggle0_v0", 32'(out0_valid), 32'h1);
        chk("s6_toggle0_d0", 32'(out0_data),  32'h77);
        chk("s6_toggle0_v1", 32'(out1_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        nerr++;
        $display("FAIL timeout observed=running expected=finished");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1, "timeout");
    end
endmodule
